// File: rtl/instr_fetch.sv
// Instruction fetch stage: program counter, synchronous-memory read addressing
// and an instruction register with valid, stale-load error and load count.
module instr_fetch #(
    parameter int PC_W = 7
) (
    input  logic            clk,
    input  logic            Reset,
    input  logic            PC_clr,
    input  logic            PC_up,
    input  logic            IR_Id,
    output logic [PC_W-1:0] imem_addr,
    output logic            imem_rd,
    input  logic [15:0]     imem_data,
    output logic [PC_W-1:0] PC,
    output logic [15:0]     IR,
    output logic            IR_valid,
    output logic            fetch_err,
    output logic [15:0]     instr_count
);

    logic [PC_W-1:0] pc_reg;
    logic [PC_W-1:0] pc_next;
    logic [15:0]     ir_reg;
    logic [15:0]     ir_next;
    logic            ir_valid_reg;
    logic            ir_valid_next;
    logic            fetch_err_reg;
    logic            fetch_err_next;
    logic [15:0]     instr_count_reg;
    logic [15:0]     instr_count_next;
    logic            data_ok_reg;
    logic            load_ok;
    logic            load_stale;

    // The memory is addressed with the next PC so its registered output lines
    // up with the PC value the controller sees in the following cycle.
    always_comb begin
        pc_next = pc_reg;
        if (!Reset) begin
            pc_next = '0;
        end else if (PC_clr) begin
            pc_next = '0;
        end else if (PC_up) begin
            pc_next = pc_reg + PC_W'(1);
        end
    end

    assign imem_addr = pc_next;
    assign imem_rd   = Reset;

    // Memory output is stale in the first cycle after reset release because
    // no read was issued while reset was held.
    assign load_ok    = IR_Id & data_ok_reg;
    assign load_stale = IR_Id & ~data_ok_reg;

    always_comb begin
        ir_next          = ir_reg;
        ir_valid_next    = ir_valid_reg;
        fetch_err_next   = fetch_err_reg;
        instr_count_next = instr_count_reg;
        if (load_ok) begin
            ir_next       = imem_data;
            ir_valid_next = 1'b1;
            if (instr_count_reg != 16'hFFFF) begin
                instr_count_next = instr_count_reg + 16'd1;
            end
        end else if (load_stale) begin
            ir_valid_next  = 1'b0;
            fetch_err_next = 1'b1;
        end else if (PC_clr) begin
            ir_valid_next = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        data_ok_reg <= Reset;
        if (!Reset) begin
            pc_reg          <= '0;
            ir_reg          <= 16'h0000;
            ir_valid_reg    <= 1'b0;
            fetch_err_reg   <= 1'b0;
            instr_count_reg <= 16'h0000;
        end else begin
            pc_reg          <= pc_next;
            ir_reg          <= ir_next;
            ir_valid_reg    <= ir_valid_next;
            fetch_err_reg   <= fetch_err_next;
            instr_count_reg <= instr_count_next;
        end
    end

    assign PC          = pc_reg;
    assign IR          = ir_reg;
    assign IR_valid    = ir_valid_reg;
    assign fetch_err   = fetch_err_reg;
    assign instr_count = instr_count_reg;

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed scenarios plus random request
// sequences compared against a cycle-level behavioural model.
module tb_instr_fetch;

    localparam int PC_W  = 7;
    localparam int DEPTH = 1 << PC_W;

    logic            clk = 1'b0;
    logic            Reset = 1'b0;
    logic            PC_clr = 1'b0;
    logic            PC_up = 1'b0;
    logic            IR_Id = 1'b0;
    logic [PC_W-1:0] imem_addr;
    logic            imem_rd;
    logic [15:0]     imem_data = 16'h0000;
    logic [PC_W-1:0] PC;
    logic [15:0]     IR;
    logic            IR_valid;
    logic            fetch_err;
    logic [15:0]     instr_count;

    int vectors = 0;
    int miscompares = 0;

    logic [15:0] mem [0:DEPTH-1];

    // Behavioural model state
    int   pc_m = 0;
    int   ir_m = 0;
    bit   valid_m = 0;
    bit   err_m = 0;
    int   count_m = 0;
    bit   prev_reset_m = 0;

    instr_fetch #(.PC_W(PC_W)) dut (
        .clk(clk), .Reset(Reset), .PC_clr(PC_clr), .PC_up(PC_up), .IR_Id(IR_Id),
        .imem_addr(imem_addr), .imem_rd(imem_rd), .imem_data(imem_data),
        .PC(PC), .IR(IR), .IR_valid(IR_valid), .fetch_err(fetch_err),
        .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    // Synchronous instruction memory: data one cycle after address.
    always @(posedge clk) begin
        if (imem_rd) imem_data <= mem[imem_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ".PC"}, 32'(PC), 32'(pc_m));
        chk({tag, ".IR"}, 32'(IR), 32'(ir_m));
        chk({tag, ".IR_valid"}, 32'(IR_valid), 32'(valid_m));
        chk({tag, ".fetch_err"}, 32'(fetch_err), 32'(err_m));
        chk({tag, ".instr_count"}, 32'(instr_count), 32'(count_m));
    endtask

    // One clock: drive requests, check the combinational memory address,
    // advance the model across the edge, then check registered outputs.
    task automatic cycle(input string tag, input bit r, input bit clr, input bit up,
                         input bit ld, input bit do_chk);
        int exp_addr;
        Reset = r; PC_clr = clr; PC_up = up; IR_Id = ld;
        #1;
        if (!r)       exp_addr = 0;
        else if (clr) exp_addr = 0;
        else if (up)  exp_addr = (pc_m + 1) % DEPTH;
        else          exp_addr = pc_m;
        if (do_chk) begin
            chk({tag, ".imem_addr"}, 32'(imem_addr), 32'(exp_addr));
            chk({tag, ".imem_rd"}, 32'(imem_rd), 32'(r));
        end
        @(posedge clk);
        if (!r) begin
            pc_m = 0; ir_m = 0; valid_m = 0; err_m = 0; count_m = 0;
        end else begin
            if (ld) begin
                // Data is trustworthy only if reset was already released on the previous edge.
                if (prev_reset_m) begin
                    ir_m = mem[pc_m];
                    valid_m = 1;
                    if (count_m < 16'hFFFF) count_m++;
                end else begin
                    valid_m = 0;
                    err_m = 1;
                end
            end else if (clr) begin
                valid_m = 0;
            end
            pc_m = exp_addr;
        end
        prev_reset_m = r;
        #1;
        if (do_chk) check_outputs(tag);
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = 16'($urandom);
        mem[0] = 16'h3536; mem[1] = 16'h4125; mem[2] = 16'h26AA; mem[3] = 16'h1A6A;

        // Reset held with every request asserted: reset wins.
        cycle("rst0", 0, 1, 1, 1, 1);
        cycle("rst1", 0, 0, 1, 1, 1);

        // Release, clear PC, then fetch word 0.
        cycle("rel_clr", 1, 1, 0, 0, 1);
        cycle("fetch0", 1, 0, 1, 1, 1);
        chk("fetch0.IR_const", 32'(IR), 32'h3536);
        chk("fetch0.PC_const", 32'(PC), 32'd1);

        // Fetch / Decode / Execute over words 1..3.
        for (int w = 1; w <= 3; w++) begin
            cycle("fde_fetch", 1, 0, 1, 1, 1);
            cycle("fde_decode", 1, 0, 0, 0, 1);
            cycle("fde_exec", 1, 0, 0, 0, 1);
        end
        chk("fde.IR_const", 32'(IR), 32'h1A6A);
        chk("fde.PC_const", 32'(PC), 32'd4);
        chk("fde.count_const", 32'(instr_count), 32'd4);

        // Random request mix.
        for (int i = 0; i < 400; i++) begin
            cycle("rand", 1, ($urandom_range(0, 9) == 0), $urandom_range(0, 1) == 1,
                  $urandom_range(0, 1) == 1, 1);
        end

        // PC wrap at all-ones, then load word 0.
        cycle("wrap_clr", 1, 1, 0, 0, 1);
        for (int i = 0; i < DEPTH - 1; i++) cycle("wrap_up", 1, 0, 1, 0, 0);
        chk("wrap.PC_top", 32'(PC), 32'(DEPTH - 1));
        cycle("wrap", 1, 0, 1, 0, 1);
        cycle("wrap_ld", 1, 0, 0, 1, 1);
        chk("wrap_ld.IR_const", 32'(IR), 32'h3536);

        // PC_clr beats PC_up; PC_clr with load keeps the load.
        cycle("c5_clr", 1, 1, 0, 0, 1);
        for (int i = 0; i < 5; i++) cycle("c5_up", 1, 0, 1, 0, 1);
        cycle("clr_up", 1, 1, 1, 0, 1);
        for (int i = 0; i < 5; i++) cycle("c5_up", 1, 0, 1, 0, 1);
        cycle("clr_ld", 1, 1, 0, 1, 1);
        chk("clr_ld.IR_word5", 32'(IR), 32'(mem[5]));

        // Load in first cycle after release is stale; error sticks through PC_clr.
        cycle("stale_rst", 0, 0, 0, 0, 1);
        cycle("stale_ld", 1, 0, 0, 1, 1);
        chk("stale.err_const", 32'(fetch_err), 32'd1);
        cycle("stale_clr", 1, 1, 0, 0, 1);
        cycle("stale_idle", 1, 0, 0, 0, 1);

        // Saturate the load counter.
        cycle("sat_rst", 0, 0, 0, 0, 1);
        cycle("sat_rel", 1, 0, 0, 0, 1);
        for (int i = 0; i < 65535; i++) cycle("sat_run", 1, 0, 1, 1, 0);
        check_outputs("sat_full");
        chk("sat_full.count_const", 32'(instr_count), 32'hFFFF);
        cycle("sat_more", 1, 0, 1, 1, 1);
        chk("sat_more.count_const", 32'(instr_count), 32'hFFFF);

        // Reset mid-run with requests active.
        cycle("midrst", 0, 1, 1, 1, 1);
        chk("midrst.count_const", 32'(instr_count), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
